// File: rtl/canny_pkg.sv
// Types and widths shared across the Canny pipeline: magnitude/angle widths,
// the {mag, angle} pixel word and the row feeder state encoding.
package canny_pkg;

    localparam int MAG_W = 20;
    localparam int ANG_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        FLUSH
    } rowfeed_state_t;

    typedef struct packed {
        logic [MAG_W-1:0] mag;
        logic [ANG_W-1:0] angle;
    } pixel_t;

endpackage

// File: rtl/mag_row_feeder_line_buffer.sv
// Circular delay line: dout is the word written DEPTH enabled cycles ago.
// Latency: DEPTH enables; no backpressure, advances only on en.
// Only the pointer is reset; stale contents are never observed because the feeder fills rows before emitting.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // Read-before-write at the same slot gives exactly DEPTH cycles of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/mag_row_feeder.sv
// Three-row magnitude window (R0 top, R1 centre, R2 current) for NMS; 1-cycle registered output.
// Backpressure: in_ready low only while flushing the bottom pad rows (ROWFEED_EDGE_PAD_EN); no output stall.
// ROWFEED_EDGE_PAD_EN: zero-pad top/bottom so every input row becomes a centre row.
module mag_row_feeder #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int MAG_W      = canny_pkg::MAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_sof,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAG_W-1:0] in_mag,
    input  logic [1:0]       in_angle,
    output logic             out_valid,
    output logic [MAG_W-1:0] R0,
    output logic [MAG_W-1:0] R1,
    output logic [MAG_W-1:0] R2,
    output logic [1:0]       out_angle,
    output logic             out_eof
);

    import canny_pkg::*;

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
`ifdef ROWFEED_EDGE_PAD_EN
    localparam int FILL_LAST_ROW = 0;
`else
    localparam int FILL_LAST_ROW = 1;
`endif

    rowfeed_state_t   state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             lb_en;
    pixel_t           lb1_din;
    pixel_t           lb1_dout;
    logic [MAG_W-1:0] lb0_dout;

    assign in_ready = (state != FLUSH);
    assign accept   = in_valid & in_ready;
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));

    // While flushing, zeros are shifted in so the buffered bottom rows drain out.
    always_comb begin
        lb1_din = '0;
        lb_en   = accept;
        if (accept) begin
            lb1_din.mag   = in_mag;
            lb1_din.angle = in_angle;
        end
`ifdef ROWFEED_EDGE_PAD_EN
        if (state == FLUSH) begin
            lb_en = 1'b1;
        end
`endif
    end

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH ($bits(pixel_t))
    ) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (lb_en),
        .din  (lb1_din),
        .dout (lb1_dout)
    );

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (MAG_W)
    ) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (lb_en),
        .din  (lb1_dout.mag),
        .dout (lb0_dout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            R0        <= '0;
            R1        <= '0;
            R2        <= '0;
            out_angle <= '0;
        end else begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            // A sof beat is pixel (0,0) from any accepting state; older rows are simply ignored.
            if (accept && in_sof) begin
                state <= FILL;
                col   <= CW'(1);
                row   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    FILL: begin
                        if (accept) begin
                            col <= last_col ? '0 : col + CW'(1);
                            row <= last_col ? row + RW'(1) : row;
                            if (last_col && row == RW'(FILL_LAST_ROW)) begin
                                state <= STREAM;
                            end
                        end
                    end
                    STREAM: begin
                        if (accept) begin
                            out_valid <= 1'b1;
                            R2        <= in_mag;
                            R1        <= lb1_dout.mag;
                            out_angle <= lb1_dout.angle;
`ifdef ROWFEED_EDGE_PAD_EN
                            R0        <= (row == RW'(1)) ? '0 : lb0_dout;
`else
                            R0        <= lb0_dout;
`endif
                            if (last_col && last_row) begin
                                col <= '0;
                                row <= '0;
`ifdef ROWFEED_EDGE_PAD_EN
                                state <= FLUSH;
`else
                                out_eof <= 1'b1;
                                state   <= IDLE;
`endif
                            end else begin
                                col <= last_col ? '0 : col + CW'(1);
                                row <= last_col ? row + RW'(1) : row;
                            end
                        end
                    end
`ifdef ROWFEED_EDGE_PAD_EN
                    FLUSH: begin
                        out_valid <= 1'b1;
                        R2        <= '0;
                        R1        <= lb1_dout.mag;
                        R0        <= lb0_dout;
                        out_angle <= lb1_dout.angle;
                        if (last_col) begin
                            out_eof <= 1'b1;
                            col     <= '0;
                            state   <= IDLE;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mag_row_feeder.sv
// Directed bench for mag_row_feeder on a 4x4 frame; expectations come from the
// pixel formula mag = base + 10*row + col, angle = (row + col) % 4.
module tb_mag_row_feeder;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int MW = 20;
`ifdef ROWFEED_EDGE_PAD_EN
    localparam bit PAD = 1'b1;
    localparam int NV  = W * H + W;
`else
    localparam bit PAD = 1'b0;
    localparam int NV  = W * H;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_sof = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in_mag = '0;
    logic [1:0]    in_angle = '0;
    logic          out_valid;
    logic [MW-1:0] R0, R1, R2;
    logic [1:0]    out_angle;
    logic          out_eof;

    always #5 clk = ~clk;

    mag_row_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .MAG_W      (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .R0        (R0),
        .R1        (R1),
        .R2        (R2),
        .out_angle (out_angle),
        .out_eof   (out_eof)
    );

    typedef struct {
        logic          sof;
        logic          vld;
        logic [MW-1:0] mag;
        logic [1:0]    ang;
        logic          e_vld;
        logic [MW-1:0] e_r0;
        logic [MW-1:0] e_r1;
        logic [MW-1:0] e_r2;
        logic [1:0]    e_ang;
        logic          e_eof;
        logic          e_rdy;
    } vec_t;

    vec_t tbl [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One frame of records; trailing W records are the self-generated pad columns.
    task automatic build(input int base);
        for (int k = 0; k < NV; k++) begin
            if (k < W * H) begin
                int r, c;
                r = k / W;
                c = k % W;
                tbl[k].sof   = (k == 0);
                tbl[k].vld   = 1'b1;
                tbl[k].mag   = MW'(base + 10 * r + c);
                tbl[k].ang   = 2'((r + c) % 4);
                tbl[k].e_vld = PAD ? (r >= 1) : (r >= 2);
                tbl[k].e_r2  = MW'(base + 10 * r + c);
                tbl[k].e_r1  = (r >= 1) ? MW'(base + 10 * (r - 1) + c) : '0;
                tbl[k].e_r0  = (r >= 2) ? MW'(base + 10 * (r - 2) + c) : '0;
                tbl[k].e_ang = 2'((r + 3 + c) % 4);
                tbl[k].e_eof = !PAD && (k == W * H - 1);
                tbl[k].e_rdy = !(PAD && (k == W * H - 1));
            end else begin
                int j;
                j = k - W * H;
                tbl[k].sof   = 1'b0;
                tbl[k].vld   = 1'b0;
                tbl[k].mag   = '0;
                tbl[k].ang   = '0;
                tbl[k].e_vld = 1'b1;
                tbl[k].e_r2  = '0;
                tbl[k].e_r1  = MW'(base + 10 * (H - 1) + j);
                tbl[k].e_r0  = MW'(base + 10 * (H - 2) + j);
                tbl[k].e_ang = 2'((H - 1 + j) % 4);
                tbl[k].e_eof = (j == W - 1);
                tbl[k].e_rdy = (j == W - 1);
            end
        end
    endtask

    task automatic apply(input int k, input string tag);
        in_sof   = tbl[k].sof;
        in_valid = tbl[k].vld;
        in_mag   = tbl[k].mag;
        in_angle = tbl[k].ang;
        @(posedge clk);
        #1;
        check($sformatf("%s_vld k=%0d", tag, k), 32'(out_valid), 32'(tbl[k].e_vld));
        check($sformatf("%s_eof k=%0d", tag, k), 32'(out_eof), 32'(tbl[k].e_eof));
        check($sformatf("%s_rdy k=%0d", tag, k), 32'(in_ready), 32'(tbl[k].e_rdy));
        if (tbl[k].e_vld) begin
            check($sformatf("%s_r0 k=%0d", tag, k), 32'(R0), 32'(tbl[k].e_r0));
            check($sformatf("%s_r1 k=%0d", tag, k), 32'(R1), 32'(tbl[k].e_r1));
            check($sformatf("%s_r2 k=%0d", tag, k), 32'(R2), 32'(tbl[k].e_r2));
            check($sformatf("%s_ang k=%0d", tag, k), 32'(out_angle), 32'(tbl[k].e_ang));
        end
        in_sof   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run(input int first, input int last, input bit gap, input string tag);
        for (int k = first; k <= last; k++) begin
            apply(k, tag);
            if (gap && k < W * H - 1) begin
                @(posedge clk);
                #1;
                check($sformatf("%s_gapvld k=%0d", tag, k), 32'(out_valid), 32'd0);
                check($sformatf("%s_gapeof k=%0d", tag, k), 32'(out_eof), 32'd0);
            end
        end
    endtask

    initial begin
        #2 rst = 1'b0;
        #10;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_eof", 32'(out_eof), 32'd0);
        check("rst_r0", 32'(R0), 32'd0);
        check("rst_r1", 32'(R1), 32'd0);
        check("rst_r2", 32'(R2), 32'd0);
        check("rst_ang", 32'(out_angle), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        build(0);
        run(0, NV - 1, 1'b0, "cont");
        run(0, NV - 1, 1'b1, "gap");

        // Frame abandoned at pixel (2,1) by a new sof.
        run(0, 2 * W, 1'b0, "pre");
        build(100);
        run(0, NV - 1, 1'b0, "restart");

        // Asynchronous reset in the middle of STREAM.
        build(0);
        run(0, 2 * W + 2, 1'b0, "prerst");
        #2 rst = 1'b0;
        #1;
        check("midrst_rdy", 32'(in_ready), 32'd1);
        check("midrst_vld", 32'(out_valid), 32'd0);
        check("midrst_eof", 32'(out_eof), 32'd0);
        check("midrst_r0", 32'(R0), 32'd0);
        check("midrst_r1", 32'(R1), 32'd0);
        check("midrst_r2", 32'(R2), 32'd0);
        check("midrst_ang", 32'(out_angle), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 2 * W * H; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_mag   = MW'(500 + i);
            in_angle = 2'(i % 4);
            @(posedge clk);
            #1;
            check($sformatf("orphan_vld i=%0d", i), 32'(out_valid), 32'd0);
            check($sformatf("orphan_rdy i=%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;

        build(200);
        run(0, NV - 1, 1'b0, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
